bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single core memory bus between two bus masters: m0, the host interface, and m1, a second requester such as a loader/DMA or debug engine.
- Presents one master port to the core bus slave.
- Arbitrates requests round-robin and holds a grant until the request is accepted.
- Tracks outstanding reads in an in-order tag FIFO so that each read response is routed back to the master that issued it.

Parameters:
- DEPTH, 4, maximum outstanding reads; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- m0_req_ready  output  1  m0 request accepted this cycle.
- m0_req_read  input  1  m0 read request.
- m0_req_write  input  1  m0 write request.
- m0_req_address  input  AW  m0 address.
- m0_req_data  input  DW  m0 write data.
- m0_res_valid  output  1  read response for m0.
- m0_res_data  output  DW  read data to m0.
- m1_*  same set as m0_*, for master 1.
- s_req_ready  input  1  slave accepts the presented request.
- s_req_read  output  1  forwarded read.
- s_req_write  output  1  forwarded write.
- s_req_address  output  AW  forwarded address.
- s_req_data  output  DW  forwarded write data.
- s_res_valid  input  1  slave read response.
- s_res_data  input  DW  slave read data.
- outstanding  output  log2(DEPTH)+1  reads in flight.
- err  output  1  sticky: a response arrived with no outstanding read.

Behaviour:
- Bus rules:
  - A master request is "req" = read|write.
  - A transfer occurs on a cycle where the forwarded req and s_req_ready are both 1.
  - Masters hold address, data and type stable until their mX_req_ready is 1.
  - Writes produce no response.
  - The slave returns read responses in order, at least 1 cycle after acceptance.
- State:
  - lock (1b), owner (1b), last (1b, last master served).
  - Tag FIFO: DEPTH x 1b master IDs, with read pointer, write pointer and count.
- Reset (reset=0, async):
  - lock=0, last=1 (m0 wins first tie), FIFO emptied, count=0, err=0.
  - All outputs driven by registered state read 0.
  - Combinational forwarding outputs are 0 while no master is granted.
- Arbitration, when unlocked:
  - Winner is the only requester, or !last if both request; winner is selected in the same cycle.
  - The winner's request is forwarded to the slave combinationally, with zero added latency.
  - No requester: s_req_read = s_req_write = 0; s_req_address and s_req_data hold the m0 values (don't-care).
- Grant hold:
  - Winner forwarded and not accepted: next cycle lock=1, owner=winner.
  - While locked, only owner is forwarded, whatever the other master does.
  - On acceptance: lock=0, last=granted master.
- Ready: mX_req_ready = granted==X & s_req_ready & !read_blocked. The non-granted master always sees ready=0.
- Read blocking:
  - read_blocked = granted read & count==DEPTH.
  - While blocked, s_req_read is forced to 0 and the grant is held (lock=1).
  - No bypass: a pop in the same cycle does not unblock the read until the next cycle.
  - Writes are never blocked.
- Tag push: on an accepted read, push the granted ID.
- Illegal request (read and write both 1): forwarded unchanged and treated as a read for tagging and blocking.
- Response routing:
  - s_res_data is fanned to both mX_res_data unconditionally.
  - On s_res_valid with count>0: mX_res_valid=1 for X = FIFO head (combinational, same cycle), then pop.
  - On s_res_valid with count==0: both res_valid=0, err set sticky until reset, nothing popped.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- outstanding = count, registered.
- Reset mid-transaction drops all tags. Any later stray response sets err.

Test Plan:
- Only m0 reads addr 0x100, s_req_ready=1, slave responds 2 cycles later with 0xDEADBEEF → m0_req_ready=1 in the request cycle; m0_res_valid=1 with 0xDEADBEEF; m1_res_valid stays 0; outstanding goes 0→1→0.
- Both masters write continuously, s_req_ready=1 → grants alternate m0, m1, m0, m1 starting with m0 after reset; exactly one mX_req_ready per cycle.
- m1 wins and s_req_ready=0 for 3 cycles while m0 requests → s_req_address stays m1's for all 3 cycles; m1 is accepted on cycle 4; m0 is granted on cycle 5.
- m0 issues 4 reads with no responses (DEPTH=4), then a 5th read → s_req_read=0 and m0_req_ready=0 while outstanding=4. After 1 response: the read is forwarded the following cycle and outstanding reads 4.
- Interleaved reads m0, m1, m1, m0, then responses 0xA, 0xB, 0xC, 0xD → valid pulses go to m0, m1, m1, m0 with matching data.
- s_res_valid=1 with nothing outstanding → no mX_res_valid; err=1 and stays 1. Assert reset=0 → err=0 and outstanding=0 immediately (asynchronous).

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory-bus slave.
// An in-order tag FIFO routes each read response back to the master that issued the read.
module bus_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   m0_req_ready,
  input  logic                   m0_req_read,
  input  logic                   m0_req_write,
  input  logic [AW-1:0]          m0_req_address,
  input  logic [DW-1:0]          m0_req_data,
  output logic                   m0_res_valid,
  output logic [DW-1:0]          m0_res_data,
  output logic                   m1_req_ready,
  input  logic                   m1_req_read,
  input  logic                   m1_req_write,
  input  logic [AW-1:0]          m1_req_address,
  input  logic [DW-1:0]          m1_req_data,
  output logic                   m1_res_valid,
  output logic [DW-1:0]          m1_res_data,
  input  logic                   s_req_ready,
  output logic                   s_req_read,
  output logic                   s_req_write,
  output logic [AW-1:0]          s_req_address,
  output logic [DW-1:0]          s_req_data,
  input  logic                   s_res_valid,
  input  logic [DW-1:0]          s_res_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] tag_q;

  logic req0, req1;
  logic gnt_valid, gnt_id;
  logic g_read, g_write, g_req;
  logic read_blocked, accept, push, pop;

  // Arbitration and handshake decode shared by next-state and output logic
  always_comb begin
    req0    = m0_req_read | m0_req_write;
    req1    = m1_req_read | m1_req_write;
    gnt_valid = lock_q | req0 | req1;
    gnt_id    = 1'b0;
    if (lock_q)             gnt_id = owner_q;
    else if (req0 && req1)  gnt_id = ~last_q;
    else if (req1)          gnt_id = 1'b1;
    g_read  = gnt_valid & (gnt_id ? m1_req_read  : m0_req_read);
    g_write = gnt_valid & (gnt_id ? m1_req_write : m0_req_write);
    g_req   = g_read | g_write;
    // A full tag FIFO stalls a read (illegal read+write included); the pop takes effect next cycle
    read_blocked = g_read & (count_q == CW'(DEPTH));
    accept  = g_req & s_req_ready & ~read_blocked;
    push    = accept & g_read;
    pop     = s_res_valid & (count_q != '0);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) tag_q[wr_ptr_q] <= gnt_id;
    end
  end

  // Next-state logic
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      lock_d = 1'b0;
      last_d = gnt_id;
    end else if (g_req) begin
      lock_d  = 1'b1;
      owner_d = gnt_id;
    end else begin
      lock_d = 1'b0;
    end
    if (s_res_valid && count_q == '0) err_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output logic: zero-latency forwarding and same-cycle response routing
  always_comb begin
    s_req_read    = g_read & ~read_blocked;
    s_req_write   = g_write & ~read_blocked;
    s_req_address = gnt_id ? m1_req_address : m0_req_address;
    s_req_data    = gnt_id ? m1_req_data    : m0_req_data;
    m0_req_ready  = gnt_valid & ~gnt_id & s_req_ready & ~read_blocked;
    m1_req_ready  = gnt_valid &  gnt_id & s_req_ready & ~read_blocked;
    m0_res_valid  = pop & ~tag_q[rd_ptr_q];
    m1_res_valid  = pop &  tag_q[rd_ptr_q];
    m0_res_data   = s_res_data;
    m1_res_data   = s_res_data;
  end

  assign outstanding = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a read-tag scoreboard for response routing.
module tb_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_req_ready, m0_req_read, m0_req_write, m0_res_valid;
  logic [31:0] m0_req_address, m0_req_data, m0_res_data;
  logic        m1_req_ready, m1_req_read, m1_req_write, m1_res_valid;
  logic [31:0] m1_req_address, m1_req_data, m1_res_data;
  logic        s_req_ready, s_req_read, s_req_write, s_res_valid;
  logic [31:0] s_req_address, s_req_data, s_res_data;
  logic [2:0]  outstanding;
  logic        err;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  bus_arbiter #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .m0_req_ready(m0_req_ready), .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
    .m0_req_address(m0_req_address), .m0_req_data(m0_req_data),
    .m0_res_valid(m0_res_valid), .m0_res_data(m0_res_data),
    .m1_req_ready(m1_req_ready), .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
    .m1_req_address(m1_req_address), .m1_req_data(m1_req_data),
    .m1_res_valid(m1_res_valid), .m1_res_data(m1_res_data),
    .s_req_ready(s_req_ready), .s_req_read(s_req_read), .s_req_write(s_req_write),
    .s_req_address(s_req_address), .s_req_data(s_req_data),
    .s_res_valid(s_res_valid), .s_res_data(s_res_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; samples land on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_masters();
    m0_req_read = 0; m0_req_write = 0; m0_req_address = '0; m0_req_data = '0;
    m1_req_read = 0; m1_req_write = 0; m1_req_address = '0; m1_req_data = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_masters();
    s_req_ready = 0; s_res_valid = 0; s_res_data = '0;
    exp_q.delete();
    #2;
    reset = 1;
    next_cycle();
  endtask

  // Drive one slave response and compare routing against the oldest expected tag
  task automatic respond(input string tag, input logic [31:0] d);
    bit id;
    s_res_valid = 1;
    s_res_data  = d;
    #4;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      id = exp_q.pop_front();
      check({tag, "_v0"}, 32'(m0_res_valid), 32'(id == 1'b0));
      check({tag, "_v1"}, 32'(m1_res_valid), 32'(id == 1'b1));
      check({tag, "_data"}, id ? m1_res_data : m0_res_data, d);
    end
    next_cycle();
    s_res_valid = 0;
  endtask

  initial begin
    clock = 0;
    reset = 0;
    clear_masters();
    s_req_ready = 0; s_res_valid = 0; s_res_data = '0;
    #1;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_read", 32'(s_req_read), 32'd0);
    check("rst_s_write", 32'(s_req_write), 32'd0);
    check("rst_m0_ready", 32'(m0_req_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    next_cycle();

    // Single m0 read, response two cycles after acceptance
    m0_req_read = 1; m0_req_address = 32'h100; s_req_ready = 1;
    #4;
    check("t1_m0_ready", 32'(m0_req_ready), 32'd1);
    check("t1_m1_ready", 32'(m1_req_ready), 32'd0);
    check("t1_s_read", 32'(s_req_read), 32'd1);
    check("t1_s_addr", s_req_address, 32'h100);
    exp_q.push_back(1'b0);
    next_cycle();
    m0_req_read = 0;
    #4;
    check("t1_outst_1", 32'(outstanding), 32'd1);
    next_cycle();
    respond("t1_resp", 32'hDEADBEEF);
    #4;
    check("t1_outst_0", 32'(outstanding), 32'd0);
    next_cycle();

    // Both masters write back-to-back: strict alternation starting with m0
    do_reset();
    s_req_ready = 1;
    m0_req_write = 1; m0_req_address = 32'h10; m0_req_data = 32'h1;
    m1_req_write = 1; m1_req_address = 32'h20; m1_req_data = 32'h2;
    for (int i = 0; i < 6; i++) begin
      #4;
      check($sformatf("t2_m0_ready_%0d", i), 32'(m0_req_ready), 32'(i % 2 == 0));
      check($sformatf("t2_m1_ready_%0d", i), 32'(m1_req_ready), 32'(i % 2 == 1));
      check($sformatf("t2_addr_%0d", i), s_req_address, (i % 2 == 0) ? 32'h10 : 32'h20);
      check($sformatf("t2_write_%0d", i), 32'(s_req_write), 32'd1);
      next_cycle();
    end
    clear_masters();

    // Grant held on m1 through three stalled cycles while m0 waits
    do_reset();
    s_req_ready = 0;
    m1_req_write = 1; m1_req_address = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #4;
      check($sformatf("t3_hold_addr_%0d", i), s_req_address, 32'h200);
      check($sformatf("t3_hold_m0rdy_%0d", i), 32'(m0_req_ready), 32'd0);
      next_cycle();
      m0_req_write = 1; m0_req_address = 32'h300;
    end
    s_req_ready = 1;
    #4;
    check("t3_c4_m1_ready", 32'(m1_req_ready), 32'd1);
    check("t3_c4_m0_ready", 32'(m0_req_ready), 32'd0);
    check("t3_c4_addr", s_req_address, 32'h200);
    next_cycle();
    m1_req_write = 0;
    #4;
    check("t3_c5_m0_ready", 32'(m0_req_ready), 32'd1);
    check("t3_c5_addr", s_req_address, 32'h300);
    next_cycle();
    clear_masters();

    // Full tag FIFO blocks a fifth read until the cycle after a pop
    do_reset();
    s_req_ready = 1;
    m0_req_read = 1;
    for (int i = 0; i < 4; i++) begin
      m0_req_address = 32'h400 + 32'(i * 4);
      #4;
      check($sformatf("t4_fill_ready_%0d", i), 32'(m0_req_ready), 32'd1);
      exp_q.push_back(1'b0);
      next_cycle();
    end
    m0_req_address = 32'h410;
    #4;
    check("t4_blk_s_read", 32'(s_req_read), 32'd0);
    check("t4_blk_ready", 32'(m0_req_ready), 32'd0);
    check("t4_blk_outst", 32'(outstanding), 32'd4);
    next_cycle();
    s_res_valid = 1; s_res_data = 32'h11;
    #4;
    check("t4_pop_v0", 32'(m0_res_valid), 32'(exp_q.pop_front() == 1'b0));
    check("t4_nobypass_s_read", 32'(s_req_read), 32'd0);
    check("t4_nobypass_ready", 32'(m0_req_ready), 32'd0);
    next_cycle();
    s_res_valid = 0;
    #4;
    check("t4_unblk_s_read", 32'(s_req_read), 32'd1);
    check("t4_unblk_ready", 32'(m0_req_ready), 32'd1);
    check("t4_unblk_addr", s_req_address, 32'h410);
    exp_q.push_back(1'b0);
    next_cycle();
    m0_req_read = 0;
    #4;
    check("t4_outst_4", 32'(outstanding), 32'd4);
    next_cycle();
    for (int i = 0; i < 4; i++) respond($sformatf("t4_drain_%0d", i), 32'h50 + 32'(i));
    #4;
    check("t4_outst_0", 32'(outstanding), 32'd0);
    next_cycle();

    // Interleaved reads m0,m1,m1,m0 routed back in order
    do_reset();
    s_req_ready = 1;
    begin
      bit ids[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] dat[4] = '{32'hA, 32'hB, 32'hC, 32'hD};
      for (int i = 0; i < 4; i++) begin
        clear_masters();
        if (ids[i]) begin m1_req_read = 1; m1_req_address = 32'h600 + 32'(i); end
        else        begin m0_req_read = 1; m0_req_address = 32'h500 + 32'(i); end
        #4;
        check($sformatf("t5_ready_%0d", i), 32'(ids[i] ? m1_req_ready : m0_req_ready), 32'd1);
        exp_q.push_back(ids[i]);
        next_cycle();
      end
      clear_masters();
      #4;
      check("t5_outst_4", 32'(outstanding), 32'd4);
      next_cycle();
      for (int i = 0; i < 4; i++) respond($sformatf("t5_resp_%0d", i), dat[i]);
    end

    // Stray response sets sticky err; async reset clears state immediately
    s_res_valid = 1; s_res_data = 32'h77;
    #4;
    check("t6_stray_v0", 32'(m0_res_valid), 32'd0);
    check("t6_stray_v1", 32'(m1_res_valid), 32'd0);
    next_cycle();
    s_res_valid = 0;
    #4;
    check("t6_err_set", 32'(err), 32'd1);
    next_cycle();
    m0_req_read = 1; m0_req_address = 32'h700;
    next_cycle();
    m0_req_read = 0;
    #4;
    check("t6_err_sticky", 32'(err), 32'd1);
    check("t6_outst_1", 32'(outstanding), 32'd1);
    next_cycle();
    #2 reset = 0;
    #1;
    check("t6_async_err", 32'(err), 32'd0);
    check("t6_async_outst", 32'(outstanding), 32'd0);
    next_cycle();
    reset = 1;
    exp_q.delete();
    next_cycle();
    s_res_valid = 1; s_res_data = 32'h88;
    #4;
    check("t6_dropped_v0", 32'(m0_res_valid), 32'd0);
    next_cycle();
    s_res_valid = 0;
    #4;
    check("t6_dropped_err", 32'(err), 32'd1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
